instr_fetch_unit: RTL

- Per-core instruction fetch front end; the requesting side of the instruction memory read interface.
- Owns the PC and drives a word-aligned byte address to the instruction memory. The memory returns the 32-bit word combinationally in the same cycle.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports pipeline redirect (branch/jump) with flush. One instance per core.

---
 rtl/instr_fetch_unit_if.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 85 ++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction memory read port, redirect request and
// the decoupled {pc, instr} stream towards decode.
interface instr_fetch_unit_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   imem_addr_o;
    logic [31:0]   imem_instr_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [31:0]   instr_o;
    logic [31:0]   pc_o;
    logic [CW-1:0] count_o;

    // Fetch unit side.
    modport master (
        output imem_addr_o,
        input  imem_instr_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output pc_o,
        output count_o
    );

    // Memory / decode / redirect side.
    modport slave (
        input  imem_addr_o,
        output imem_instr_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  pc_o,
        input  count_o
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads a combinational instruction
// memory and buffers {pc, instr} pairs in a small FIFO for decode.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk_i,
    input logic                 rst_i,
    instr_fetch_unit_if.master  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];

    logic valid;
    logic pop;
    logic push;

    assign valid = (count_q != '0);
    assign pop   = valid & bus.instr_ready_i;
    // A full FIFO still accepts a fetch when the head leaves in the same cycle.
    assign push  = !bus.redirect_i & ((count_q < CW'(DEPTH)) | pop);

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.redirect_i) begin
            // Flush wins over push and pop; the presented head is killed.
            pc_d     = {bus.redirect_pc_i[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else if (push) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_instr_q[wr_ptr_q] <= bus.imem_instr_i;
        end
    end

    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_valid_o = valid;
    assign bus.count_o       = count_q;
    assign bus.instr_o       = valid ? mem_instr_q[rd_ptr_q] : '0;
    assign bus.pc_o          = valid ? mem_pc_q[rd_ptr_q] : '0;

endmodule
